// File: rtl/bomb_ctrl.sv
`default_nettype none
// bomb_ctrl: per-frame bomb lifecycle (drop, fuse, blast, cooldown) with a
// registered lethal-region output for the player block.
module bomb_ctrl #(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int COOL_FRAMES  = 15,
  parameter int GRID         = 16,
  parameter int BLAST_R      = 24
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  output logic [9:0] bomb1X,
  output logic [9:0] bomb1Y,
  output logic [9:0] bomb1S,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic       bomb_visible,
  output logic       blast_active,
  output logic [7:0] fuse_cnt,
  output logic       bomb_done
);

  localparam logic [7:0] FUSE_LOAD  = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0] BLAST_LOAD = 8'(BLAST_FRAMES - 1);
  localparam logic [7:0] COOL_LOAD  = 8'(COOL_FRAMES - 1);
  localparam logic [9:0] SNAP_MASK  = ~10'(GRID - 1);
  localparam logic [9:0] REACH      = 10'(BLAST_R);
  localparam logic [9:0] SIDE       = 10'(GRID + 2 * BLAST_R);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t     state;
  logic [9:0] snap_x;
  logic [9:0] snap_y;
  logic [9:0] blast_x;
  logic [9:0] blast_y;

  assign snap_x  = userX & SNAP_MASK;
  assign snap_y  = userY & SNAP_MASK;
  // Region origin saturates at the screen's left/top edge instead of wrapping.
  assign blast_x = (bombX >= REACH) ? bombX - REACH : 10'd0;
  assign blast_y = (bombY >= REACH) ? bombY - REACH : 10'd0;

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state        <= IDLE;
      fuse_cnt     <= 8'd0;
      bombX        <= 10'd0;
      bombY        <= 10'd0;
      bomb1X       <= 10'd0;
      bomb1Y       <= 10'd0;
      bomb1S       <= 10'd0;
      bomb_visible <= 1'b0;
      blast_active <= 1'b0;
      bomb_done    <= 1'b0;
    end else begin
      bomb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bomb_drop) begin
            state        <= ARMED;
            fuse_cnt     <= FUSE_LOAD;
            bombX        <= snap_x;
            bombY        <= snap_y;
            bomb_visible <= 1'b1;
          end
        end
        ARMED: begin
          if (fuse_cnt != 8'd0) begin
            fuse_cnt <= fuse_cnt - 8'd1;
          end else begin
            state        <= BLAST;
            fuse_cnt     <= BLAST_LOAD;
            blast_active <= 1'b1;
            bomb1X       <= blast_x;
            bomb1Y       <= blast_y;
            bomb1S       <= SIDE;
          end
        end
        BLAST: begin
          if (fuse_cnt != 8'd0) begin
            fuse_cnt <= fuse_cnt - 8'd1;
          end else begin
            state        <= COOLDOWN;
            fuse_cnt     <= COOL_LOAD;
            blast_active <= 1'b0;
            bomb_visible <= 1'b0;
            bomb1X       <= 10'd0;
            bomb1Y       <= 10'd0;
            bomb1S       <= 10'd0;
            bomb_done    <= 1'b1;
          end
        end
        COOLDOWN: begin
          if (fuse_cnt != 8'd0) begin
            fuse_cnt <= fuse_cnt - 8'd1;
          end else if (bomb_drop) begin
            // A held drop re-arms on the frame IDLE would be entered, giving
            // back-to-back cycles of exactly FUSE+BLAST+COOL frames.
            state        <= ARMED;
            fuse_cnt     <= FUSE_LOAD;
            bombX        <= snap_x;
            bombY        <= snap_y;
            bomb_visible <= 1'b1;
          end else begin
            state    <= IDLE;
            fuse_cnt <= 8'd0;
          end
        end
        default: begin
          state    <= IDLE;
          fuse_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 SHALL have parameter FUSE_FRAMES, default 120, giving the frames from drop to detonation (legal range 1..255).
REQ-002 SHALL have parameter BLAST_FRAMES, default 30, giving the frames the blast region is live (legal range 1..255).
REQ-003 SHALL have parameter COOL_FRAMES, default 15, giving the frames after the blast before a new drop is accepted (legal range 1..255).
REQ-004 SHALL have parameter GRID, default 16, giving the tile pitch in pixels (power of two).
REQ-005 SHALL have parameter BLAST_R, default 24, giving the blast reach in pixels beyond the tile edge.
REQ-006 frame_clk  in  1  the single clock, one rising edge per video frame.
REQ-007 Reset  in  1  reset, synchronous and active-low, sampled on rising frame_clk.
REQ-008 bomb_drop  in  1  drop request from the player block; level-sensitive.
REQ-009 userX, userY  in  10 each  current player position in pixels.
REQ-010 bomb1X, bomb1Y, bomb1S  out  10 each  lethal region (top-left corner and side length) consumed by the player block.
REQ-011 bombX, bombY  out  10 each  snapped bomb tile origin, for drawing.
REQ-012 bomb_visible  out  1  high in ARMED and BLAST.
REQ-013 blast_active  out  1  high in BLAST only.
REQ-014 fuse_cnt  out  8  remaining frames in the current timed state.
REQ-015 bomb_done  out  1  one-frame pulse on the BLAST-to-COOLDOWN transition.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, ARMED, BLAST and COOLDOWN; state, counter and all outputs SHALL be registered on frame_clk.
REQ-017 In IDLE with bomb_drop=1, next state SHALL be ARMED, with bombX = userX & ~(GRID-1), bombY = userY & ~(GRID-1), and fuse_cnt = FUSE_FRAMES-1.
REQ-018 In IDLE with bomb_drop=0, the FSM SHALL remain in IDLE.
REQ-019 In any timed state with fuse_cnt != 0, fuse_cnt SHALL decrement by 1 per frame.
REQ-020 In any timed state with fuse_cnt == 0, the FSM SHALL advance: ARMED->BLAST (load BLAST_FRAMES-1), BLAST->COOLDOWN (load COOL_FRAMES-1), COOLDOWN->IDLE (fuse_cnt=0).
REQ-021 Each timed state SHALL therefore last exactly its parameter in frames.
REQ-022 bomb_drop SHALL be ignored in ARMED, BLAST and COOLDOWN; there is no queueing, and a level still held on entry to IDLE SHALL start a new bomb on that frame.
REQ-023 bombX and bombY SHALL latch only on the IDLE->ARMED transition and hold until the next drop; player motion after the drop SHALL not move the bomb.
REQ-024 In IDLE, ARMED and COOLDOWN, outputs SHALL be bomb1X = bomb1Y = bomb1S = 0, a zero-size region that can never collide.
REQ-025 In BLAST, bomb1X SHALL be bombX-BLAST_R when bombX >= BLAST_R, else 0; bomb1Y SHALL follow the same rule on bombY.
REQ-026 In BLAST, bomb1S SHALL be GRID+2*BLAST_R; no right or bottom clipping is applied, and the consumer bounds-checks.
REQ-027 All position arithmetic SHALL be 10-bit unsigned; subtraction SHALL saturate at 0 and never wrap.
REQ-028 bomb_done SHALL be 1 only in the first COOLDOWN frame and 0 otherwise.
REQ-029 When userX or userY is 0, the snap SHALL give tile 0 with no special case.

Reset
REQ-030 While Reset=0 at a rising edge: state=IDLE; fuse_cnt=0; bombX, bombY, bomb1X, bomb1Y, bomb1S=0; bomb_visible, blast_active, bomb_done=0.
REQ-031 Reset asserted in any state, including mid-BLAST, SHALL abort the bomb with no bomb_done pulse.
REQ-032 The first frame after Reset returns to 1 SHALL behave as IDLE, so a held bomb_drop is accepted on that frame.

Verification
REQ-033 Basic drop: userX=100, userY=50, bomb_drop pulsed 1 frame -> bombX=96, bombY=48, bomb_visible=1.
REQ-034 Fuse timing (basic drop continued): blast_active rises exactly 120 frames after the drop frame; bomb1X=72, bomb1Y=24, bomb1S=64.
REQ-035 Blast and cooldown timing (basic drop continued): blast_active is high for exactly 30 frames; bomb_done pulses once; IDLE is reached 15 frames later.
REQ-036 Edge saturation: userX=5, userY=470 -> bombX=0, bombY=464; in BLAST, bomb1X=0, bomb1Y=440, bomb1S=64.
REQ-037 Held drop: bomb_drop held 1 for 400 frames -> exactly two full bomb cycles of 165 frames each, with the second ARMED starting on the frame IDLE is entered; during ARMED, player moves by 40 px and bombX/bombY do not change.
REQ-038 Reset mid-blast: Reset=0 for 1 frame at BLAST frame 10 -> next frame all outputs are 0, bomb_done never pulses, and a fresh drop is accepted afterwards.
